// File: rtl/fsm_trans_cond_gen.sv
// fsm_trans_cond_gen: transition-condition generator for a one-hot FSM.
// Tracks how long the FSM has sat in its present state, compares that dwell
// against a per-state programmable threshold, and combines it with the
// per-state external event according to a per-state mode. Also flags any
// multi-hot state vector with a sticky error bit.
module fsm_trans_cond_gen #(
  parameter int P_NUM_STATE = 8,
  parameter int P_CNT_W     = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [P_NUM_STATE-1:0]         I_STATE,
  input  logic [P_NUM_STATE-1:0]         I_EVENT,
  input  logic                           I_CFG_WE,
  input  logic [$clog2(P_NUM_STATE)-1:0] I_CFG_IDX,
  input  logic [P_CNT_W-1:0]             I_CFG_DWELL,
  input  logic [1:0]                     I_CFG_MODE,
  input  logic                           I_ERR_CLR,
  output logic [P_NUM_STATE-1:0]         O_TRANS_COND,
  output logic [P_CNT_W-1:0]             O_DWELL_CNT,
  output logic                           O_ONEHOT_ERR
);

  localparam int L_IDX_W = $clog2(P_NUM_STATE);

  localparam logic [1:0] L_MODE_EVENT       = 2'd0;
  localparam logic [1:0] L_MODE_TIMEOUT     = 2'd1;
  localparam logic [1:0] L_MODE_EVT_AND_MIN = 2'd2;
  localparam logic [1:0] L_MODE_EVT_OR_TO   = 2'd3;

  localparam logic [P_CNT_W-1:0]     L_CNT_MAX   = {P_CNT_W{1'b1}};
  localparam logic [P_CNT_W-1:0]     L_CNT_ONE   = P_CNT_W'(1);
  localparam logic [P_NUM_STATE-1:0] L_STATE_ONE = P_NUM_STATE'(1);
  localparam logic [L_IDX_W:0]       L_NUM_EXT   = (L_IDX_W+1)'(P_NUM_STATE);

  // Exactly one bit set.
  function automatic logic f_is_onehot(input logic [P_NUM_STATE-1:0] v);
    return (v != '0) && ((v & (v - L_STATE_ONE)) == '0);
  endfunction

  // Two or more bits set (all-zero is not multi-hot).
  function automatic logic f_is_multihot(input logic [P_NUM_STATE-1:0] v);
    return (v & (v - L_STATE_ONE)) != '0;
  endfunction

  // Index of the highest set bit; only meaningful for a one-hot vector.
  function automatic logic [L_IDX_W-1:0] f_index(input logic [P_NUM_STATE-1:0] v);
    logic [L_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < P_NUM_STATE; k++) begin
      if (v[k]) begin
        idx = L_IDX_W'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [P_NUM_STATE-1:0] st_q, st_d;
  logic [P_CNT_W-1:0]     cnt_q, cnt_d;
  logic [P_NUM_STATE-1:0] trans_q, trans_d;
  logic                   err_q, err_d;
  logic [P_CNT_W-1:0]     dwell_q [P_NUM_STATE];
  logic [P_CNT_W-1:0]     dwell_d [P_NUM_STATE];
  logic [1:0]             mode_q  [P_NUM_STATE];
  logic [1:0]             mode_d  [P_NUM_STATE];

  logic                   valid_s;
  logic                   multi_s;
  logic [L_IDX_W-1:0]     idx_s;
  logic [P_CNT_W-1:0]     e_s;
  logic                   hit_s;
  logic                   cond_s;
  logic                   cfg_in_range_s;

  // Dwell tracking, condition selection and error flag next-state.
  always_comb begin
    valid_s = f_is_onehot(I_STATE);
    multi_s = f_is_multihot(I_STATE);
    idx_s   = f_index(I_STATE);
    st_d    = I_STATE;

    // Cycles already spent in the present state; zero on the entry cycle.
    if (valid_s && (I_STATE == st_q)) begin
      e_s = cnt_q;
    end else begin
      e_s = '0;
    end

    hit_s = (e_s >= dwell_q[idx_s]);

    case (mode_q[idx_s])
      L_MODE_EVENT:       cond_s = I_EVENT[idx_s];
      L_MODE_TIMEOUT:     cond_s = hit_s;
      L_MODE_EVT_AND_MIN: cond_s = I_EVENT[idx_s] && hit_s;
      L_MODE_EVT_OR_TO:   cond_s = I_EVENT[idx_s] || hit_s;
      default:            cond_s = 1'b0;
    endcase

    if (!valid_s) begin
      cnt_d   = '0;
      trans_d = '0;
    end else if (e_s == L_CNT_MAX) begin
      cnt_d   = L_CNT_MAX;
      trans_d = P_NUM_STATE'(cond_s) << idx_s;
    end else begin
      cnt_d   = e_s + L_CNT_ONE;
      trans_d = P_NUM_STATE'(cond_s) << idx_s;
    end

    // A new multi-hot observation beats a coincident clear.
    if (multi_s) begin
      err_d = 1'b1;
    end else if (I_ERR_CLR) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Per-state dwell/mode table write; out-of-range indices are dropped.
  always_comb begin
    dwell_d        = dwell_q;
    mode_d         = mode_q;
    cfg_in_range_s = ({1'b0, I_CFG_IDX} < L_NUM_EXT);
    if (I_CFG_WE && cfg_in_range_s) begin
      dwell_d[I_CFG_IDX] = I_CFG_DWELL;
      mode_d[I_CFG_IDX]  = I_CFG_MODE;
    end else begin
      dwell_d = dwell_q;
      mode_d  = mode_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= '0;
      cnt_q   <= '0;
      trans_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < P_NUM_STATE; k++) begin
        dwell_q[k] <= '0;
        mode_q[k]  <= L_MODE_EVENT;
      end
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      trans_q <= trans_d;
      err_q   <= err_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
    end
  end

  assign O_TRANS_COND = trans_q;
  assign O_DWELL_CNT  = cnt_q;
  assign O_ONEHOT_ERR = err_q;

endmodule

// File: doc/fsm_trans_cond_gen.md
Name: fsm_trans_cond_gen

Overview:
Upstream condition generator for the team's parameterised one-hot FSM. It watches the FSM's registered one-hot state vector and per-state external events. It produces the per-state transition-condition vector from a per-state programmable dwell timer and mode. It also flags illegal (multi-hot) state vectors.

Parameters:
P_NUM_STATE, 8, number of FSM states; width of all state, event and condition vectors
P_CNT_W, 8, width of dwell counter and per-state dwell config; counter saturates at 2**P_CNT_W-1

Ports:
clk  input  1  clock, all flops on rising edge
rstn  input  1  asynchronous active-low reset
I_STATE  input  P_NUM_STATE  FSM present state (one-hot; all-zero legal = FSM idle/reset)
I_EVENT  input  P_NUM_STATE  external event per state, level-sensitive
I_CFG_WE  input  1  config write strobe
I_CFG_IDX  input  $clog2(P_NUM_STATE)  state index for config write
I_CFG_DWELL  input  P_CNT_W  dwell threshold written to entry I_CFG_IDX
I_CFG_MODE  input  2  mode written to entry I_CFG_IDX
I_ERR_CLR  input  1  clears O_ONEHOT_ERR
O_TRANS_COND  output  P_NUM_STATE  registered transition conditions, fed to FSM condition input
O_DWELL_CNT  output  P_CNT_W  registered dwell counter (cnt)
O_ONEHOT_ERR  output  1  sticky multi-hot error flag

Behaviour:
- Reset (async, rstn=0): O_TRANS_COND=0, O_DWELL_CNT=0, O_ONEHOT_ERR=0, st_q=0, all dwell entries=0, all modes=0 (EVENT). Reset mid-dwell abandons the count; no pulse is produced.
- Definitions per cycle: valid = I_STATE has exactly one bit set; stable = valid && (I_STATE==st_q); e = stable ? cnt : 0 (cycles already spent in the current state); i = index of the set bit.
- Counter update: st_q<=I_STATE every cycle. If valid, cnt<=sat(e+1), saturating at max. If not valid, cnt<=0.
- Timing: a state entered in cycle T gives e=0,1,2,... in cycles T,T+1,T+2,...
- hit = (e >= dwell[i]).
- Mode per state i:
  - 0 EVENT: cond=I_EVENT[i]
  - 1 TIMEOUT: cond=hit
  - 2 EVENT_AND_MIN: cond=I_EVENT[i]&&hit
  - 3 EVENT_OR_TIMEOUT: cond=I_EVENT[i]||hit
- Output: O_TRANS_COND<=valid ? (cond<<i) : 0. Latency is 1 cycle from the qualifying cycle. At most one bit is set. Bits for non-active states are always 0.
- A TIMEOUT condition stays asserted every cycle until I_STATE changes. The FSM consumes the first assertion.
- A stale bit one cycle after a state change is harmless, because the FSM masks with its present state.
- Saturation: cnt holds at max. With dwell=max, hit stays true once max is reached.
- Config write: when I_CFG_WE=1 and I_CFG_IDX<P_NUM_STATE, dwell/mode[idx] update at the clock edge. Indices >=P_NUM_STATE are ignored.
  - A write to the active state is used from the next cycle.
  - A write does not reset cnt.
  - With a new dwell <= e, hit is immediate.
- Error flag:
  - Multi-hot I_STATE sets O_ONEHOT_ERR at the next edge. It is sticky.
  - I_ERR_CLR clears it. If set and clear occur in the same cycle, set wins.
  - All-zero I_STATE is not an error: no conditions, cnt<=0.
- Wrap-around: a state change from the last state to state 0 is handled like any other change; cnt restarts.

Test Plan:
1. Reset defaults: after rstn release, I_STATE=8'h01, I_EVENT=8'h01 in cycle T -> O_TRANS_COND=8'h01 at T+1 (EVENT mode). Prior to release all outputs are 0.
2. TIMEOUT: write idx2 dwell=3 mode=1; I_STATE=8'h04 from cycle T, I_EVENT=0 -> O_TRANS_COND=0 through T+3, 8'h04 from T+4. O_DWELL_CNT reads 1,2,3,4 at T+1..T+4.
3. EVENT_AND_MIN: idx5 dwell=2 mode=2; enter state 5 at T with I_EVENT[5]=1 at T+1 -> no pulse; I_EVENT[5]=1 at T+2 -> O_TRANS_COND=8'h20 at T+3.
4. Closed loop with the FSM (P_NUM_STATE=8), all states TIMEOUT dwell=1, FSM started in state 7 -> FSM wraps 7->0. Each state is held for exactly 3 cycles (2 dwell + 1 latency). O_DWELL_CNT restarts at each change.
5. Error: I_STATE=8'h03 one cycle -> O_ONEHOT_ERR=1 next cycle, O_TRANS_COND=0, cnt=0. Flag holds through valid states. I_ERR_CLR alone -> 0. Clear coincident with 8'h81 -> stays 1.
6. Saturation and config: P_CNT_W=2, idx0 dwell=3 mode=1, hold state 0 for 10 cycles -> cnt sticks at 3, condition stays high. Mid-hold write idx0 dwell=0 -> no glitch. Write with I_CFG_IDX=7 at P_NUM_STATE=6 -> no entry changes.
